// File: rtl/snake_body_engine_if.sv
// Control, fruit, query and status bundle between the game side and the snake body engine.
// The engine connects through the slave modport; the game/tick/renderer side through master.
interface snake_body_engine_if #(
  parameter int COORD_BIT = 7,
  parameter int LEN_BIT   = 7
);
  logic                 start;
  logic                 game_tik;
  logic                 right_P;
  logic                 left_P;
  logic [COORD_BIT-1:0] fruit_x;
  logic [COORD_BIT-1:0] fruit_y;
  logic [COORD_BIT-1:0] query_x;
  logic [COORD_BIT-1:0] query_y;
  logic                 query_hit;
  logic                 query_head;
  logic                 query_tail;
  logic [COORD_BIT-1:0] snake_head_x;
  logic [COORD_BIT-1:0] snake_head_y;
  logic [1:0]           direction;
  logic [LEN_BIT-1:0]   snake_length;
  logic [LEN_BIT-1:0]   score;
  logic                 fruit_eaten;
  logic                 collision_detected;
  logic                 busy;

  modport master (
    output start, game_tik, right_P, left_P, fruit_x, fruit_y, query_x, query_y,
    input  query_hit, query_head, query_tail, snake_head_x, snake_head_y, direction,
           snake_length, score, fruit_eaten, collision_detected, busy
  );

  modport slave (
    input  start, game_tik, right_P, left_P, fruit_x, fruit_y, query_x, query_y,
    output query_hit, query_head, query_tail, snake_head_x, snake_head_y, direction,
           snake_length, score, fruit_eaten, collision_detected, busy
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body: segment shift register, step/grow/collide FSM, registered 1-cycle occupancy queries.
// No backpressure: game_tik during the CHECK scan is dropped. SNAKE_WRAP_AROUND_EN wraps grid edges.
module snake_body_engine #(
  parameter int COORD_BIT  = 7,
  parameter int GRID_X_MAX = 79,
  parameter int GRID_Y_MAX = 59,
  parameter int MAX_LEN    = 16,
  parameter int LEN_BIT    = 7,
  parameter int START_X    = 40,
  parameter int START_Y    = 30,
  parameter int START_LEN  = 3
) (
  input logic              clock_25,
  input logic              reset,
  snake_body_engine_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_LEN);

  typedef logic [COORD_BIT-1:0] coord_t;
  typedef logic [LEN_BIT-1:0]   len_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CHECK, ST_DEAD} state_t;

  localparam coord_t X_MAX = coord_t'(GRID_X_MAX);
  localparam coord_t Y_MAX = coord_t'(GRID_Y_MAX);

  function automatic coord_t init_x(int i);
    return (i < START_LEN) ? coord_t'(START_X - i) : '0;
  endfunction

  function automatic coord_t init_y(int i);
    return (i < START_LEN) ? coord_t'(START_Y) : '0;
  endfunction

  state_t             state_q, state_d;
  coord_t             seg_x_q [MAX_LEN];
  coord_t             seg_x_d [MAX_LEN];
  coord_t             seg_y_q [MAX_LEN];
  coord_t             seg_y_d [MAX_LEN];
  logic [1:0]         dir_q, dir_d;
  len_t               len_q, len_d;
  len_t               score_q, score_d;
  logic               turn_vld_q, turn_vld_d;
  logic               turn_cw_q, turn_cw_d;
  logic [IDX_W-1:0]   chk_q, chk_d;
  logic               fruit_eaten_q, fruit_eaten_d;
  logic               qhit_q, qhit_d;
  logic               qhead_q, qhead_d;
  logic               qtail_q, qtail_d;

  logic               press_one;
  logic [1:0]         step_dir;
  coord_t             new_x, new_y;
  logic               wall;

  assign press_one = bus.right_P ^ bus.left_P;

  // Candidate head for a step; a turn pressed in the tick cycle itself still counts if none is latched.
  always_comb begin
    step_dir = dir_q;
    if (turn_vld_q)
      step_dir = turn_cw_q ? dir_q + 2'd1 : dir_q - 2'd1;
    else if (press_one)
      step_dir = bus.right_P ? dir_q + 2'd1 : dir_q - 2'd1;
    new_x = seg_x_q[0];
    new_y = seg_y_q[0];
    wall  = 1'b0;
    case (step_dir)
      2'd0: begin
        if (seg_x_q[0] >= X_MAX) begin
`ifdef SNAKE_WRAP_AROUND_EN
          new_x = '0;
`else
          wall = 1'b1;
`endif
        end else new_x = seg_x_q[0] + coord_t'(1);
      end
      2'd1: begin
        if (seg_y_q[0] >= Y_MAX) begin
`ifdef SNAKE_WRAP_AROUND_EN
          new_y = '0;
`else
          wall = 1'b1;
`endif
        end else new_y = seg_y_q[0] + coord_t'(1);
      end
      2'd2: begin
        if (seg_x_q[0] == '0) begin
`ifdef SNAKE_WRAP_AROUND_EN
          new_x = X_MAX;
`else
          wall = 1'b1;
`endif
        end else new_x = seg_x_q[0] - coord_t'(1);
      end
      default: begin
        if (seg_y_q[0] == '0) begin
`ifdef SNAKE_WRAP_AROUND_EN
          new_y = Y_MAX;
`else
          wall = 1'b1;
`endif
        end else new_y = seg_y_q[0] - coord_t'(1);
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    seg_x_d       = seg_x_q;
    seg_y_d       = seg_y_q;
    dir_d         = dir_q;
    len_d         = len_q;
    score_d       = score_q;
    turn_vld_d    = turn_vld_q;
    turn_cw_d     = turn_cw_q;
    chk_d         = chk_q;
    fruit_eaten_d = 1'b0;
    qhit_d        = 1'b0;
    qhead_d       = 1'b0;
    qtail_d       = 1'b0;

    for (int i = 0; i < MAX_LEN; i++) begin
      if (seg_x_q[i] == bus.query_x && seg_y_q[i] == bus.query_y) begin
        if (len_t'(i) < len_q) qhit_d = 1'b1;
        if (i == 0) qhead_d = 1'b1;
        if (len_t'(i) == len_q - len_t'(1)) qtail_d = 1'b1;
      end
    end

    if (bus.start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = init_y(i);
      end
      dir_d      = 2'd0;
      len_d      = len_t'(START_LEN);
      score_d    = '0;
      turn_vld_d = 1'b0;
      turn_cw_d  = 1'b0;
      chk_d      = IDX_W'(1);
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.game_tik) begin
            dir_d      = step_dir;
            turn_vld_d = 1'b0;
            if (wall) begin
              state_d = ST_DEAD;
            end else begin
              // Shifting every entry keeps the old tail one slot further down, ready for growth.
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_d[i] = seg_x_q[i-1];
                seg_y_d[i] = seg_y_q[i-1];
              end
              seg_x_d[0] = new_x;
              seg_y_d[0] = new_y;
              if (new_x == bus.fruit_x && new_y == bus.fruit_y) begin
                len_d         = (len_q >= len_t'(MAX_LEN)) ? len_q : len_q + len_t'(1);
                score_d       = (&score_q) ? score_q : score_q + len_t'(1);
                fruit_eaten_d = 1'b1;
              end
              chk_d   = IDX_W'(1);
              state_d = ST_CHECK;
            end
          end else if (!turn_vld_q && press_one) begin
            turn_vld_d = 1'b1;
            turn_cw_d  = bus.right_P;
          end
        end
        ST_CHECK: begin
          if (seg_x_q[chk_q] == seg_x_q[0] && seg_y_q[chk_q] == seg_y_q[0])
            state_d = ST_DEAD;
          else if (chk_q == IDX_W'(len_q - len_t'(1)))
            state_d = ST_RUN;
          else
            chk_d = chk_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
      dir_q         <= 2'd0;
      len_q         <= len_t'(START_LEN);
      score_q       <= '0;
      turn_vld_q    <= 1'b0;
      turn_cw_q     <= 1'b0;
      chk_q         <= IDX_W'(1);
      fruit_eaten_q <= 1'b0;
      qhit_q        <= 1'b0;
      qhead_q       <= 1'b0;
      qtail_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_x_q       <= seg_x_d;
      seg_y_q       <= seg_y_d;
      dir_q         <= dir_d;
      len_q         <= len_d;
      score_q       <= score_d;
      turn_vld_q    <= turn_vld_d;
      turn_cw_q     <= turn_cw_d;
      chk_q         <= chk_d;
      fruit_eaten_q <= fruit_eaten_d;
      qhit_q        <= qhit_d;
      qhead_q       <= qhead_d;
      qtail_q       <= qtail_d;
    end
  end

  assign bus.query_hit          = qhit_q;
  assign bus.query_head         = qhead_q;
  assign bus.query_tail         = qtail_q;
  assign bus.snake_head_x       = seg_x_q[0];
  assign bus.snake_head_y       = seg_y_q[0];
  assign bus.direction          = dir_q;
  assign bus.snake_length       = len_q;
  assign bus.score              = score_q;
  assign bus.fruit_eaten        = fruit_eaten_q;
  assign bus.collision_detected = (state_q == ST_DEAD);
  assign bus.busy               = (state_q == ST_CHECK);
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus random play against a queue-based body model.
`timescale 1ns/1ps
module tb_snake_body_engine;
  localparam int CB = 7, LB = 7, MAXL = 16, SX = 40, SY = 30, SL = 3, XM = 79, YM = 59;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  snake_body_engine_if #(.COORD_BIT(CB), .LEN_BIT(LB)) bus();

  snake_body_engine #(
    .COORD_BIT(CB), .GRID_X_MAX(XM), .GRID_Y_MAX(YM), .MAX_LEN(MAXL),
    .LEN_BIT(LB), .START_X(SX), .START_Y(SY), .START_LEN(SL)
  ) dut (
    .clock_25(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #20 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_CHECK, M_DEAD} mstate_e;
  mstate_e m_state;
  int  bx[$];
  int  by[$];
  int  m_dir, m_score, m_chk_left;
  bit  m_turn_vld, m_turn_cw, m_chk_dead, m_fe, m_qh, m_qhd, m_qt;

  function automatic void init_body();
    bx.delete();
    by.delete();
    for (int i = 0; i < SL; i++) begin
      bx.push_back(SX - i);
      by.push_back(SY);
    end
  endfunction

  function automatic void model_reset();
    init_body();
    m_state = M_IDLE; m_dir = 0; m_score = 0; m_turn_vld = 0; m_turn_cw = 0;
    m_fe = 0; m_qh = 0; m_qhd = 0; m_qt = 0; m_chk_left = 0; m_chk_dead = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently on the bus.
  function automatic void model_edge();
    int n, nx, ny, k;
    bit one, wall, grow;
    n = bx.size();
    m_qh = 0; m_qhd = 0; m_qt = 0;
    for (int i = 0; i < n; i++)
      if (bx[i] == int'(bus.query_x) && by[i] == int'(bus.query_y)) begin
        m_qh = 1;
        if (i == 0) m_qhd = 1;
        if (i == n - 1) m_qt = 1;
      end
    m_fe = 0;
    if (bus.start) begin
      init_body();
      m_dir = 0; m_score = 0; m_turn_vld = 0; m_state = M_RUN;
      return;
    end
    one = bus.right_P ^ bus.left_P;
    case (m_state)
      M_RUN: begin
        if (bus.game_tik) begin
          if (m_turn_vld) m_dir = (m_dir + (m_turn_cw ? 1 : 3)) % 4;
          else if (one) m_dir = (m_dir + (bus.right_P ? 1 : 3)) % 4;
          m_turn_vld = 0;
          nx = bx[0]; ny = by[0];
          case (m_dir)
            0: nx = nx + 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: ny = ny - 1;
          endcase
`ifdef SNAKE_WRAP_AROUND_EN
          wall = 0;
          if (nx > XM) nx = 0;
          if (nx < 0) nx = XM;
          if (ny > YM) ny = 0;
          if (ny < 0) ny = YM;
`else
          wall = (nx < 0) || (nx > XM) || (ny < 0) || (ny > YM);
`endif
          if (wall) m_state = M_DEAD;
          else begin
            grow = (nx == int'(bus.fruit_x)) && (ny == int'(bus.fruit_y));
            bx.push_front(nx);
            by.push_front(ny);
            if (!(grow && n < MAXL)) begin
              void'(bx.pop_back());
              void'(by.pop_back());
            end
            if (grow) begin
              if (m_score < (1 << LB) - 1) m_score++;
              m_fe = 1;
            end
            k = 0;
            for (int j = 1; j < bx.size(); j++)
              if (k == 0 && bx[j] == nx && by[j] == ny) k = j;
            m_chk_dead = (k != 0);
            m_chk_left = (k != 0) ? k : bx.size() - 1;
            m_state = M_CHECK;
          end
        end else if (!m_turn_vld && one) begin
          m_turn_vld = 1;
          m_turn_cw = bus.right_P;
        end
      end
      M_CHECK: begin
        m_chk_left--;
        if (m_chk_left == 0) m_state = m_chk_dead ? M_DEAD : M_RUN;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [35:0] obs_vec();
    return {bus.snake_head_x, bus.snake_head_y, bus.direction, bus.snake_length, bus.score,
            bus.fruit_eaten, bus.collision_detected, bus.busy,
            bus.query_hit, bus.query_head, bus.query_tail};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {CB'(bx[0]), CB'(by[0]), 2'(m_dir), LB'(bx.size()), LB'(m_score),
            m_fe, (m_state == M_DEAD), (m_state == M_CHECK), m_qh, m_qhd, m_qt};
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    bus.start = 0; bus.game_tik = 0; bus.right_P = 0; bus.left_P = 0;
  endtask

  task automatic settle();
    for (int i = 0; i < 80 && m_state == M_CHECK; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #50;
    rst_n = 1;
    cyc();
  endtask

  task automatic test_reset();
    bus.query_x = 0; bus.query_y = 0;
    do_reset();
    total++; if (bus.snake_head_x !== 7'd40 || bus.snake_head_y !== 7'd30) begin bad++;
      $display("FAIL reset_head got=(%0d,%0d) want=(40,30)", bus.snake_head_x, bus.snake_head_y); end
    total++; if (bus.snake_length !== 7'd3 || bus.score !== 7'd0 || bus.direction !== 2'd0) begin bad++;
      $display("FAIL reset_len_score_dir got=%0d/%0d/%0d want=3/0/0", bus.snake_length, bus.score, bus.direction); end
    total++; if ({bus.fruit_eaten, bus.collision_detected, bus.busy, bus.query_hit, bus.query_head, bus.query_tail} !== 6'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=000000", {bus.fruit_eaten, bus.collision_detected, bus.busy, bus.query_hit, bus.query_head, bus.query_tail}); end
    bus.query_x = 38; bus.query_y = 30;
    cyc();
    total++; if ({bus.query_hit, bus.query_head, bus.query_tail} !== 3'b101) begin bad++;
      $display("FAIL idle_query_tail got=%b want=101", {bus.query_hit, bus.query_head, bus.query_tail}); end
    bus.query_x = 40;
    cyc();
    total++; if ({bus.query_hit, bus.query_head, bus.query_tail} !== 3'b110) begin bad++;
      $display("FAIL idle_query_head got=%b want=110", {bus.query_hit, bus.query_head, bus.query_tail}); end
  endtask

  task automatic test_straight();
    bus.fruit_x = 0; bus.fruit_y = 0;
    bus.start = 1; cyc();
    for (int t = 0; t < 5; t++) begin
      bus.game_tik = 1; cyc();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL straight_busy1 tick=%0d got=%b want=1", t, bus.busy); end
      cyc();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL straight_busy2 tick=%0d got=%b want=1", t, bus.busy); end
      cyc();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL straight_busy3 tick=%0d got=%b want=0", t, bus.busy); end
    end
    total++; if (bus.snake_head_x !== 7'd45 || bus.snake_head_y !== 7'd30 || bus.snake_length !== 7'd3 || bus.score !== 7'd0) begin bad++;
      $display("FAIL straight_end got=(%0d,%0d) len=%0d score=%0d want=(45,30) len=3 score=0",
               bus.snake_head_x, bus.snake_head_y, bus.snake_length, bus.score); end
  endtask

  task automatic test_fruit();
    bus.fruit_x = 41; bus.fruit_y = 30;
    bus.start = 1; cyc();
    bus.game_tik = 1; cyc();
    total++; if (bus.fruit_eaten !== 1'b1 || bus.snake_length !== 7'd4 || bus.score !== 7'd1) begin bad++;
      $display("FAIL fruit_capture got fe=%b len=%0d score=%0d want fe=1 len=4 score=1", bus.fruit_eaten, bus.snake_length, bus.score); end
    bus.query_x = 38; bus.query_y = 30;
    cyc();
    total++; if (bus.fruit_eaten !== 1'b0) begin bad++; $display("FAIL fruit_pulse_once got=%b want=0", bus.fruit_eaten); end
    total++; if (bus.query_tail !== 1'b1 || bus.query_hit !== 1'b1) begin bad++;
      $display("FAIL fruit_tail_query got tail=%b hit=%b want 1/1", bus.query_tail, bus.query_hit); end
    bus.fruit_x = 0; bus.fruit_y = 0;
    settle();
  endtask

  task automatic test_turns();
    bus.start = 1; cyc();
    bus.right_P = 1; bus.left_P = 1; cyc();
    bus.game_tik = 1; cyc();
    total++; if (bus.direction !== 2'd0 || bus.snake_head_x !== 7'd41 || bus.snake_head_y !== 7'd30) begin bad++;
      $display("FAIL turn_both got dir=%0d head=(%0d,%0d) want dir=0 head=(41,30)", bus.direction, bus.snake_head_x, bus.snake_head_y); end
    settle();
    bus.right_P = 1; cyc();
    bus.game_tik = 1; cyc();
    total++; if (bus.direction !== 2'd1 || bus.snake_head_x !== 7'd41 || bus.snake_head_y !== 7'd31) begin bad++;
      $display("FAIL turn_right got dir=%0d head=(%0d,%0d) want dir=1 head=(41,31)", bus.direction, bus.snake_head_x, bus.snake_head_y); end
    settle();
    bus.right_P = 1; cyc();
    bus.left_P = 1; cyc();
    bus.game_tik = 1; cyc();
    total++; if (bus.direction !== 2'd2 || bus.snake_head_x !== 7'd40 || bus.snake_head_y !== 7'd31) begin bad++;
      $display("FAIL turn_first_only got dir=%0d head=(%0d,%0d) want dir=2 head=(40,31)", bus.direction, bus.snake_head_x, bus.snake_head_y); end
    settle();
  endtask

  task automatic test_wall();
    bus.start = 1; cyc();
    for (int t = 0; t < 39; t++) begin
      bus.game_tik = 1; cyc();
      settle();
    end
    total++; if (bus.snake_head_x !== 7'd79) begin bad++; $display("FAIL wall_approach got x=%0d want=79", bus.snake_head_x); end
    bus.game_tik = 1; cyc();
`ifdef SNAKE_WRAP_AROUND_EN
    total++; if (bus.snake_head_x !== 7'd0 || bus.snake_head_y !== 7'd30 || bus.collision_detected !== 1'b0) begin bad++;
      $display("FAIL wall_wrap got head=(%0d,%0d) coll=%b want (0,30) coll=0", bus.snake_head_x, bus.snake_head_y, bus.collision_detected); end
    settle();
    total++; if (bus.busy !== 1'b0 || bus.collision_detected !== 1'b0) begin bad++;
      $display("FAIL wall_wrap_run got busy=%b coll=%b want 0/0", bus.busy, bus.collision_detected); end
`else
    total++; if (bus.snake_head_x !== 7'd79 || bus.collision_detected !== 1'b1) begin bad++;
      $display("FAIL wall_hit got x=%0d coll=%b want x=79 coll=1", bus.snake_head_x, bus.collision_detected); end
    bus.game_tik = 1; bus.right_P = 1; cyc();
    bus.game_tik = 1; cyc();
    total++; if (bus.snake_head_x !== 7'd79 || bus.snake_head_y !== 7'd30 || bus.collision_detected !== 1'b1) begin bad++;
      $display("FAIL wall_frozen got head=(%0d,%0d) coll=%b want (79,30) coll=1", bus.snake_head_x, bus.snake_head_y, bus.collision_detected); end
`endif
  endtask

  task automatic test_self_collision();
    bus.fruit_x = 41; bus.fruit_y = 30;
    bus.start = 1; cyc();
    bus.game_tik = 1; cyc();
    bus.fruit_x = 42; settle();
    bus.game_tik = 1; cyc();
    bus.fruit_x = 0; bus.fruit_y = 0; settle();
    total++; if (bus.snake_length !== 7'd5 || bus.score !== 7'd2) begin bad++;
      $display("FAIL self_grow got len=%0d score=%0d want 5/2", bus.snake_length, bus.score); end
    for (int t = 0; t < 2; t++) begin
      bus.right_P = 1; cyc();
      bus.game_tik = 1; cyc();
      settle();
    end
    bus.right_P = 1; cyc();
    bus.game_tik = 1; cyc();
    cyc(); cyc(); cyc();
    total++; if (bus.busy !== 1'b1 || bus.collision_detected !== 1'b0) begin bad++;
      $display("FAIL self_scanning got busy=%b coll=%b want 1/0", bus.busy, bus.collision_detected); end
    cyc();
    total++; if (bus.collision_detected !== 1'b1 || bus.busy !== 1'b0 || bus.snake_head_x !== 7'd41 || bus.snake_head_y !== 7'd30) begin bad++;
      $display("FAIL self_dead got coll=%b busy=%b head=(%0d,%0d) want 1/0 (41,30)", bus.collision_detected, bus.busy, bus.snake_head_x, bus.snake_head_y); end
    bus.start = 1; cyc();
    total++; if (bus.snake_head_x !== 7'd40 || bus.snake_length !== 7'd3 || bus.score !== 7'd0 || bus.collision_detected !== 1'b0 || bus.direction !== 2'd0) begin bad++;
      $display("FAIL self_restart got x=%0d len=%0d score=%0d coll=%b dir=%0d want 40/3/0/0/0",
               bus.snake_head_x, bus.snake_length, bus.score, bus.collision_detected, bus.direction); end
  endtask

  task automatic test_async_reset();
    bus.fruit_x = 41; bus.fruit_y = 30; bus.query_x = 40; bus.query_y = 30;
    bus.start = 1; cyc();
    bus.game_tik = 1; cyc();
    #6;
    rst_n = 0;
    #1;
    total++; if (obs_vec() !== {7'd40, 7'd30, 2'd0, 7'd3, 7'd0, 6'b0}) begin bad++;
      $display("FAIL async_reset got=%h want=%h", obs_vec(), {7'd40, 7'd30, 2'd0, 7'd3, 7'd0, 6'b0}); end
    bus.fruit_x = 0; bus.fruit_y = 0;
    do_reset();
  endtask

  task automatic test_random();
    int fails = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.start    = (m_state == M_DEAD) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      bus.game_tik = ($urandom_range(0, 3) == 0);
      bus.right_P  = ($urandom_range(0, 7) == 0);
      bus.left_P   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.fruit_x = CB'(bx[0] + int'($urandom_range(0, 4)) - 2);
        bus.fruit_y = CB'(by[0] + int'($urandom_range(0, 4)) - 2);
      end
      if ($urandom_range(0, 1) == 0) begin
        int k = $urandom_range(0, bx.size() - 1);
        bus.query_x = CB'(bx[k]); bus.query_y = CB'(by[k]);
      end else begin
        bus.query_x = CB'(bx[0] + int'($urandom_range(0, 6)) - 3);
        bus.query_y = CB'(by[0] + int'($urandom_range(0, 6)) - 3);
      end
      cyc();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (fails < 10) $display("FAIL random_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
        fails++;
      end
    end
  endtask

  initial begin
    bus.start = 0; bus.game_tik = 0; bus.right_P = 0; bus.left_P = 0;
    bus.fruit_x = 0; bus.fruit_y = 0; bus.query_x = 0; bus.query_y = 0;
    test_reset();
    test_straight();
    test_fruit();
    test_turns();
    test_wall();
    test_self_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised successor of the game-side snake logic.
- Stores the full snake body as a segment shift register of up to MAX_LEN entries and advances it on each game_tik.
- Grows the body and scores on fruit capture, detects wall and self collisions, and answers per-block occupancy queries from the renderer with fixed 1-cycle latency.
- Sits between the input synchroniser/game-tick generator and the graphics pipeline; one instance per player.

Parameters:
- COORD_BIT, 7, width of block coordinates.
- GRID_X_MAX, 79, largest legal x block index.
- GRID_Y_MAX, 59, largest legal y block index.
- MAX_LEN, 16, maximum segment count, 2..64.
- LEN_BIT, 7, width of snake_length, count and score.
- START_X, 40, head x after reset/start.
- START_Y, 30, head y after reset/start.
- START_LEN, 3, initial length, 2..MAX_LEN; body laid out horizontally to the left of the head.

Ports:
- clock_25  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; (re)initialises the snake and enters RUN.
- game_tik  in  1  1-cycle step pulse.
- right_P  in  1  synchronised 1-cycle pulse, turn clockwise.
- left_P  in  1  synchronised 1-cycle pulse, turn counter-clockwise.
- fruit_x  in  COORD_BIT  fruit x block.
- fruit_y  in  COORD_BIT  fruit y block.
- query_x  in  COORD_BIT  renderer block x.
- query_y  in  COORD_BIT  renderer block y.
- query_hit  out  1  queried block is occupied by any live segment; 1-cycle latency.
- query_head  out  1  queried block is the head; 1-cycle latency.
- query_tail  out  1  queried block is the last live segment; 1-cycle latency.
- snake_head_x  out  COORD_BIT  current head x.
- snake_head_y  out  COORD_BIT  current head y.
- direction  out  2  0=right, 1=down, 2=left, 3=up.
- snake_length  out  LEN_BIT  live segment count.
- score  out  LEN_BIT  fruits eaten, saturating at all-ones.
- fruit_eaten  out  1  1-cycle pulse on capture.
- collision_detected  out  1  level, high in DEAD.
- busy  out  1  high during CHECK.

Behaviour:
- Reset (asynchronous, active-low; applies mid-operation too):
  - state=IDLE; all segments = (START_X-i, START_Y) for i < START_LEN; unused segments = 0.
  - direction=0; snake_length=START_LEN; score=0.
  - All pulse and query outputs = 0.
- States: IDLE, RUN, CHECK, DEAD.
  - start in any state → RUN with the reset contents, except score which is also cleared.
  - start has priority over every other event in the same cycle.
- Turn latch:
  - In RUN, the first right_P or left_P since the last step is latched as the pending turn.
  - Further presses before the step are ignored.
  - right_P and left_P in the same cycle → no turn latched.
  - The latched turn is applied at the next step: direction ±1 mod 4. Relative turns make reversal impossible.
- Step (RUN and game_tik):
  - Cycle T: compute new head = head + unit vector of updated direction.
    - If new head leaves 0..GRID_X_MAX or 0..GRID_Y_MAX → DEAD at T+1; body unchanged.
    - Otherwise seg[i] ← seg[i-1] for i ≥ 1, and seg[0] ← new head.
  - If new head == (fruit_x, fruit_y):
    - snake_length increments, saturating at MAX_LEN; the previous tail is retained as the new last segment.
    - score increments, saturating.
    - fruit_eaten pulses at T+1.
  - Next state is CHECK.
- CHECK:
  - Scans one segment per cycle, i = 1..snake_length-1, comparing against seg[0]. busy=1.
  - Any match → DEAD. Scan complete → RUN.
  - Duration is snake_length-1 cycles, at most MAX_LEN-1.
  - game_tik during CHECK is dropped, not queued.
- DEAD: collision_detected=1; body frozen; ticks and turns ignored; only start or reset leaves it.
- IDLE: body visible to queries, no motion.
- Query path:
  - Parallel compare of (query_x, query_y) against all segments with index < snake_length.
  - Result is registered, so outputs are valid on the cycle after the inputs.
  - Queries are valid in every state.
- Arithmetic: coordinate arithmetic is COORD_BIT wide; out-of-range is detected before truncation (compare against 0 when decrementing and against the max when incrementing).

Optional Feature:
- Macro: SNAKE_WRAP_AROUND_EN.
- Defined:
  - Leaving the grid wraps: x=GRID_X_MAX+1 → 0 and x=-1 → GRID_X_MAX; same for y.
  - Wall collision never occurs; only self collision leads to DEAD.
- Undefined: walls are lethal as described above.

Test Plan:
- Reset then start; 5 ticks, no turns → head (45,30), length 3, busy high 2 cycles after each tick, score 0.
- Fruit at (41,30); start; one tick → fruit_eaten pulses once, length 4, score 1; query (38,30) → query_tail=1 next cycle.
- Start; right_P and left_P in the same cycle, then tick → direction stays 0; lone right_P then tick → direction 1, head (41,31).
- Macro undefined: head at (79,30) heading right; tick → collision_detected=1, head stays (79,30); further ticks ignored. Macro defined: same stimulus → head (0,30), RUN.
- Length 5, turns right, right, right over 3 ticks → self collision, DEAD after the CHECK scan; start → IDLE contents restored, score 0.
- reset asserted mid-CHECK → all outputs at reset values immediately, without waiting for a clock edge.
